// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline boundary bundle: decoded instruction from ID, registered copy in EX.
// No latency of its own; it only carries signals.
// Backpressure: ex_hold freezes EX, stall tells IF/ID to hold its slot.
//
// Ports (master = decode/driver side, slave = id_ex_stage):
//   id_*      decoded instruction presented by ID
//   flush     branch/jump taken, kill the instruction entering EX
//   ex_hold   EX busy, freeze the stage
//   ex_*      registered instruction held in EX
//   stall     hold PC and IF/ID this cycle
//   stall_cnt count of load-use bubbles inserted
interface id_ex_stage_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_uses_rt;
  logic [31:0] id_read_data1;
  logic [31:0] id_read_data2;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic        flush;
  logic        ex_hold;

  logic        ex_valid;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_imm;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        stall;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt,
           id_read_data1, id_read_data2, id_imm,
           id_alu_op, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, flush, ex_hold,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm,
           ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt,
           id_read_data1, id_read_data2, id_imm,
           id_alu_op, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, flush, ex_hold,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm,
           ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, stall, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Latency: one cycle from id_* to ex_*; stall is combinational in the same cycle.
// Backpressure: ex_hold freezes all state; a load-use hazard inserts one bubble.
//
// Ports:
//   clk  rising-edge clock
//   clr  synchronous active-high clear (all ex_* and stall_cnt to 0)
//   bus  id_ex_stage_if.slave: id_* in, flush/ex_hold in, ex_*/stall/stall_cnt out
module id_ex_stage (
  input  logic           clk,
  input  logic           clr,
  id_ex_stage_if.slave   bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_t;

  // Next-state action, listed highest priority first.
  typedef enum logic [2:0] {
    ACT_CLR,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_e;

  ex_t         ex_q, ex_d;
  ex_t         id_pkt;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;
  logic        stall;
  act_e        act;

  // Incoming instruction as it would be captured; an invalid slot carries
  // its data fields through but never any control that could cause effects.
  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = bus.id_valid;
    id_pkt.rs         = bus.id_rs;
    id_pkt.rt         = bus.id_rt;
    id_pkt.rd         = bus.id_rd;
    id_pkt.a          = bus.id_read_data1;
    id_pkt.b          = bus.id_read_data2;
    id_pkt.imm        = bus.id_imm;
    id_pkt.alu_op     = bus.id_valid ? bus.id_alu_op : 4'd0;
    id_pkt.alu_src    = bus.id_valid & bus.id_alu_src;
    id_pkt.mem_read   = bus.id_valid & bus.id_mem_read;
    id_pkt.mem_write  = bus.id_valid & bus.id_mem_write;
    id_pkt.reg_write  = bus.id_valid & bus.id_reg_write;
    id_pkt.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
  end

  // A load in EX whose result the ID instruction needs. Register 0 is
  // hard-wired so it can never be a real dependency.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & bus.id_valid &
               ((ex_q.rd == bus.id_rs) |
                (bus.id_uses_rt & (ex_q.rd == bus.id_rt)));
  end

  // Flush kills the ID instruction anyway, so a hazard against it needs no
  // stall; clr does not mask stall because it reflects current contents.
  always_comb begin
    stall = bus.ex_hold | (load_use & ~bus.flush);
  end

  always_comb begin
    act = ACT_LOAD;
    if (clr) begin
      act = ACT_CLR;
    end else if (bus.flush) begin
      act = ACT_FLUSH;
    end else if (bus.ex_hold) begin
      act = ACT_HOLD;
    end else if (load_use) begin
      act = ACT_BUBBLE;
    end
  end

  // The bubble clears ex_mem_read, so the hazard disappears on the next
  // cycle and the held ID instruction loads: exactly one bubble per hazard.
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    unique case (act)
      ACT_CLR: begin
        ex_d        = '0;
        stall_cnt_d = 16'd0;
      end
      ACT_FLUSH: begin
        ex_d = '0;
      end
      ACT_HOLD: begin
        ex_d = ex_q;
      end
      ACT_BUBBLE: begin
        ex_d = '0;
        if (stall_cnt_q != 16'hFFFF) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
      ACT_LOAD: begin
        ex_d = id_pkt;
      end
      default: begin
        ex_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    ex_q        <= ex_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_rs         = ex_q.rs;
  assign bus.ex_rt         = ex_q.rt;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_a          = ex_q.a;
  assign bus.ex_b          = ex_q.b;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.stall         = stall;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [15:0] cnt;
  } snap_t;

  snap_t sb_q[$];
  snap_t mdl;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.valid      = bus.ex_valid;
    s.rs         = bus.ex_rs;
    s.rt         = bus.ex_rt;
    s.rd         = bus.ex_rd;
    s.a          = bus.ex_a;
    s.b          = bus.ex_b;
    s.imm        = bus.ex_imm;
    s.alu_op     = bus.ex_alu_op;
    s.alu_src    = bus.ex_alu_src;
    s.mem_read   = bus.ex_mem_read;
    s.mem_write  = bus.ex_mem_write;
    s.reg_write  = bus.ex_reg_write;
    s.mem_to_reg = bus.ex_mem_to_reg;
    s.cnt        = bus.stall_cnt;
    return s;
  endfunction

  // What EX should hold after loading the instruction currently in ID.
  function automatic snap_t id_capture(input logic [15:0] cnt);
    snap_t s;
    s.valid      = bus.id_valid;
    s.rs         = bus.id_rs;
    s.rt         = bus.id_rt;
    s.rd         = bus.id_rd;
    s.a          = bus.id_read_data1;
    s.b          = bus.id_read_data2;
    s.imm        = bus.id_imm;
    s.alu_op     = bus.id_valid ? bus.id_alu_op : 4'd0;
    s.alu_src    = bus.id_valid & bus.id_alu_src;
    s.mem_read   = bus.id_valid & bus.id_mem_read;
    s.mem_write  = bus.id_valid & bus.id_mem_write;
    s.reg_write  = bus.id_valid & bus.id_reg_write;
    s.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
    s.cnt        = cnt;
    return s;
  endfunction

  task automatic clear_id();
    bus.id_valid      = 1'b0;
    bus.id_rs         = 5'd0;
    bus.id_rt         = 5'd0;
    bus.id_rd         = 5'd0;
    bus.id_uses_rt    = 1'b0;
    bus.id_read_data1 = 32'd0;
    bus.id_read_data2 = 32'd0;
    bus.id_imm        = 32'd0;
    bus.id_alu_op     = 4'd0;
    bus.id_alu_src    = 1'b0;
    bus.id_mem_read   = 1'b0;
    bus.id_mem_write  = 1'b0;
    bus.id_reg_write  = 1'b0;
    bus.id_mem_to_reg = 1'b0;
    bus.flush         = 1'b0;
    bus.ex_hold       = 1'b0;
  endtask

  // One clock: check stall against the expected EX contents, push the
  // expected next state, clock, then pop and compare with the DUT.
  task automatic step(input string tag);
    logic  lu;
    logic  exp_stall;
    snap_t nx;
    snap_t got;
    #1;
    lu = mdl.valid & mdl.mem_read & (mdl.rd != 5'd0) & bus.id_valid &
         ((mdl.rd == bus.id_rs) | (bus.id_uses_rt & (mdl.rd == bus.id_rt)));
    exp_stall = bus.ex_hold | (lu & ~bus.flush);
    chk({tag, "_stall"}, bus.stall, exp_stall);
    if (clr) begin
      nx = '0;
    end else if (bus.flush) begin
      nx = '0;
      nx.cnt = mdl.cnt;
    end else if (bus.ex_hold) begin
      nx = mdl;
    end else if (lu) begin
      nx = '0;
      nx.cnt = (mdl.cnt == 16'hFFFF) ? 16'hFFFF : mdl.cnt + 16'd1;
    end else begin
      nx = id_capture(mdl.cnt);
    end
    sb_q.push_back(nx);
    @(posedge clk);
    #1;
    got = dut_snap();
    nx  = sb_q.pop_front();
    chk(tag, got, nx);
    mdl = nx;
  endtask

  task automatic load_rd7();
    clear_id();
    bus.id_valid      = 1'b1;
    bus.id_rs         = 5'd1;
    bus.id_rd         = 5'd7;
    bus.id_mem_read   = 1'b1;
    bus.id_reg_write  = 1'b1;
    bus.id_mem_to_reg = 1'b1;
    bus.id_read_data1 = 32'h1000;
    step("ld7");
  endtask

  initial begin
    clr = 1'b1;
    clear_id();
    repeat (2) @(posedge clk);
    #1;
    mdl = '0;
    chk("reset", dut_snap(), 160'd0);
    clr = 1'b0;

    // Pass-through
    clear_id();
    bus.id_valid      = 1'b1;
    bus.id_rs         = 5'd3;
    bus.id_rt         = 5'd4;
    bus.id_rd         = 5'd5;
    bus.id_read_data1 = 32'h11;
    bus.id_read_data2 = 32'h22;
    bus.id_reg_write  = 1'b1;
    step("pass");
    chk("pass_a", bus.ex_a, 32'h11);
    chk("pass_b", bus.ex_b, 32'h22);
    chk("pass_rd", bus.ex_rd, 5'd5);
    chk("pass_rw", bus.ex_reg_write, 1'b1);

    // Load-use: one bubble, then the ID instruction loads
    load_rd7();
    clear_id();
    bus.id_valid     = 1'b1;
    bus.id_rs        = 5'd7;
    bus.id_rd        = 5'd8;
    bus.id_reg_write = 1'b1;
    #1;
    chk("lu_stall_hi", bus.stall, 1'b1);
    step("lu_bubble");
    chk("lu_bubble_v", bus.ex_valid, 1'b0);
    chk("lu_cnt", bus.stall_cnt, 16'd1);
    step("lu_load");
    chk("lu_load_v", bus.ex_valid, 1'b1);
    chk("lu_load_rs", bus.ex_rs, 5'd7);

    // No false hazard: load to r0 vs rs=0
    clear_id();
    bus.id_valid    = 1'b1;
    bus.id_rd       = 5'd0;
    bus.id_mem_read = 1'b1;
    step("ld0");
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs    = 5'd0;
    bus.id_rd    = 5'd9;
    step("r0_nohaz");
    chk("r0_valid", bus.ex_valid, 1'b1);
    chk("r0_cnt", bus.stall_cnt, 16'd1);

    // No false hazard: rt matches but is not read
    load_rd7();
    clear_id();
    bus.id_valid   = 1'b1;
    bus.id_rs      = 5'd2;
    bus.id_rt      = 5'd7;
    bus.id_uses_rt = 1'b0;
    step("rt_nohaz");
    chk("rt_valid", bus.ex_valid, 1'b1);
    chk("rt_rt", bus.ex_rt, 5'd7);

    // Priority: flush + hold + load_use together
    load_rd7();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs    = 5'd7;
    bus.flush    = 1'b1;
    bus.ex_hold  = 1'b1;
    step("prio");
    chk("prio_valid", bus.ex_valid, 1'b0);
    chk("prio_cnt", bus.stall_cnt, 16'd1);

    // Hold alone for three cycles with changing ID contents
    load_rd7();
    for (int i = 0; i < 3; i++) begin
      clear_id();
      bus.id_valid      = 1'b1;
      bus.id_rd         = 5'(i + 20);
      bus.id_read_data1 = $urandom;
      bus.ex_hold       = 1'b1;
      #1;
      chk("hold_stall", bus.stall, 1'b1);
      step("hold");
      chk("hold_rd", bus.ex_rd, 5'd7);
    end

    // Random mix biased toward hazards
    for (int i = 0; i < 400; i++) begin
      clr               = ($urandom_range(0, 31) == 0);
      bus.id_valid      = ($urandom_range(0, 7) != 0);
      bus.id_rs         = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(6, 8));
      bus.id_rt         = 5'($urandom_range(6, 8));
      bus.id_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(6, 8));
      bus.id_uses_rt    = $urandom_range(0, 1);
      bus.id_read_data1 = $urandom;
      bus.id_read_data2 = $urandom;
      bus.id_imm        = $urandom;
      bus.id_alu_op     = 4'($urandom_range(0, 15));
      bus.id_alu_src    = $urandom_range(0, 1);
      bus.id_mem_read   = $urandom_range(0, 1);
      bus.id_mem_write  = $urandom_range(0, 1);
      bus.id_reg_write  = $urandom_range(0, 1);
      bus.id_mem_to_reg = $urandom_range(0, 1);
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.ex_hold       = ($urandom_range(0, 5) == 0);
      step("rnd");
    end
    clr = 1'b0;

    // Saturation: a self-dependent load produces a bubble every other edge
    clr = 1'b1;
    clear_id();
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.id_valid    = 1'b1;
    bus.id_rs       = 5'd7;
    bus.id_rd       = 5'd7;
    bus.id_mem_read = 1'b1;
    repeat (2001) @(posedge clk);
    #1;
    chk("sat_mid", bus.stall_cnt, 16'd1000);
    repeat (129072) @(posedge clk);
    #1;
    chk("sat_full", bus.stall_cnt, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_nowrap", bus.stall_cnt, 16'hFFFF);

    // Odd edge count: EX holds the load, hazard pending; clr wins
    mdl = id_capture(16'hFFFF);
    clr = 1'b1;
    step("clr_sat");
    chk("clr_cnt", bus.stall_cnt, 16'd0);
    chk("clr_ex", dut_snap(), 160'd0);
    clr = 1'b0;
    step("post_clr");
    chk("post_clr_v", bus.ex_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-002 SHALL have: clr  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: id_valid  in  1  decode slot holds a real instruction.
REQ-004 SHALL have: id_rs, id_rt, id_rd  in  5 each  source and destination register numbers.
REQ-005 SHALL have: id_uses_rt  in  1  instruction reads rt as an operand.
REQ-006 SHALL have: id_read_data1, id_read_data2  in  32 each  register-file read ports, already write-back bypassed.
REQ-007 SHALL have: id_imm  in  32  sign-extended immediate.
REQ-008 SHALL have: id_alu_op  in  4, plus id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  decoded control.
REQ-009 SHALL have: flush  in  1  branch or jump taken; kill the instruction entering EX.
REQ-010 SHALL have: ex_hold  in  1  EX busy; freeze this stage.
REQ-011 SHALL have an ex_* output for each id_* input except id_uses_rt: ex_valid 1, ex_rs/ex_rt/ex_rd 5, ex_a/ex_b/ex_imm 32, ex_alu_op 4, ex_alu_src/ex_mem_read/ex_mem_write/ex_reg_write/ex_mem_to_reg 1. All are registered.
REQ-012 SHALL have: stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-013 SHALL have: stall_cnt  out  16  registered count of load-use bubbles inserted.

Function
REQ-014 SHALL compute load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
REQ-015 SHALL drive stall = ex_hold | (load_use & ~flush).
REQ-016 SHALL apply next-state actions at each edge, first matching wins: clr, then flush, then ex_hold, then load_use, then load.
REQ-017 On flush: insert a bubble, i.e. ex_valid = 0, all five 1-bit controls = 0, ex_alu_op = 0. Data and register fields are don't-care and SHALL be zeroed. This applies even when ex_hold = 1.
REQ-018 On ex_hold without flush: all ex_* outputs and stall_cnt SHALL retain their values.
REQ-019 On load_use without flush or hold: insert a bubble as in REQ-017, and increment stall_cnt.
REQ-020 On load: capture all id_* values. ex_valid <= id_valid. When id_valid = 0, all controls SHALL be forced to 0.
REQ-021 A load-use hazard SHALL cost exactly one bubble: the bubble clears ex_mem_read, so the held instruction loads on the following edge.
REQ-022 stall_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-023 Latency: an id_* value presented at edge N SHALL appear on ex_* after edge N, unless a higher-priority action applies at edge N.
REQ-024 A destination of register 0 SHALL never trigger load_use. It SHALL still be passed through unchanged.

Reset
REQ-025 When clr = 1 at an edge, all ex_* outputs SHALL become 0 and stall_cnt SHALL become 0, regardless of flush, ex_hold or load_use.
REQ-026 During the cycle clr is high, stall SHALL still reflect REQ-015 computed from the current register contents.
REQ-027 A clr asserted mid-stall SHALL leave a bubble and no pending hazard after the edge.

Verification
REQ-028 Pass-through: after clr, present id_valid=1, rs=3, rt=4, rd=5, data1=32'h11, data2=32'h22, reg_write=1 -> next cycle ex_a=32'h11, ex_b=32'h22, ex_rd=5, ex_reg_write=1, stall=0.
REQ-029 Load-use: EX holds a load with ex_rd=7; ID presents rs=7 -> stall=1 that cycle; then a bubble (ex_valid=0); the next edge loads the ID instruction; stall_cnt=1.
REQ-030 No false hazard: EX holds a load with rd=0 and ID rs=0, or ID rt=7 with id_uses_rt=0 -> stall=0, no bubble.
REQ-031 Priority: flush=1, ex_hold=1 and load_use all active together -> bubble inserted, stall_cnt unchanged; ex_hold=1 alone for 3 cycles -> ex_* unchanged throughout, stall=1.
REQ-032 Saturation and reset: force 65536 load-use events -> stall_cnt=16'hFFFF; assert clr -> stall_cnt=0 and all ex_* = 0 after one edge.
